// File: rtl/full_adder.sv
// 1-bit full adder cell: combinational sum/carry for ripple chains, plus a
// registered copy with a valid flag and a saturating carry-out event counter.
module full_adder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             s,
  output logic             cout,
  output logic             s_q,
  output logic             cout_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] cout_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // The combinational path does not depend on clk, rst or in_valid, so ripple
  // chains built from this cell see zero latency.
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; all state is cleared by the async reset, so no X
  // appears on any registered output once reset has been applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q       <= 1'b0;
      cout_q    <= 1'b0;
      out_valid <= 1'b0;
      cout_cnt  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s_q    <= s;
        cout_q <= cout;
        if (cout && (cout_cnt != CNT_MAX)) begin
          cout_cnt <= cout_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: a default-width instance plus a CNT_W=2
// instance sharing the same stimulus to exercise counter saturation.
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       a, b, cin, in_valid;
  logic       s, cout, s_q, cout_q, out_valid;
  logic [7:0] cout_cnt;
  logic       s2, cout2, s_q2, cout_q2, out_valid2;
  logic [1:0] cout_cnt2;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  full_adder #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .s(s), .cout(cout), .s_q(s_q), .cout_q(cout_q),
    .out_valid(out_valid), .cout_cnt(cout_cnt)
  );

  full_adder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .s(s2), .cout(cout2), .s_q(s_q2), .cout_q(cout_q2),
    .out_valid(out_valid2), .cout_cnt(cout_cnt2)
  );

  task automatic drive(input logic va, input logic vb, input logic vc, input logic vv);
    @(negedge clk);
    a = va; b = vb; cin = vc; in_valid = vv;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({s_q, cout_q, out_valid, cout_cnt} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_state got %b exp %b", {s_q, cout_q, out_valid, cout_cnt}, 11'd0);
    end
    tests_run++;
    if ({s_q2, cout_q2, out_valid2, cout_cnt2} !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_state_sat got %b exp %b", {s_q2, cout_q2, out_valid2, cout_cnt2}, 5'd0);
    end
  endtask

  task automatic test_comb();
    logic [1:0] exp_tab [8];
    exp_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      {cin, b, a} = 3'(i);
      #10;
      tests_run++;
      if ({cout, s} !== exp_tab[i]) begin
        tests_failed++;
        $display("FAIL comb_%0d got %b exp %b", i, {cout, s}, exp_tab[i]);
      end
    end
    tests_run++;
    if ({out_valid, cout_cnt} !== 9'd0) begin
      tests_failed++;
      $display("FAIL comb_no_capture got %b exp %b", {out_valid, cout_cnt}, 9'd0);
    end
  endtask

  task automatic test_registered();
    drive(1, 1, 1, 1);
    cycle();
    tests_run++;
    if ({s_q, cout_q, out_valid} !== 3'b111) begin
      tests_failed++;
      $display("FAIL registered got %b exp %b", {s_q, cout_q, out_valid}, 3'b111);
    end
    tests_run++;
    if (cout_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL registered_cnt got %0d exp %0d", cout_cnt, 1);
    end
  endtask

  task automatic test_valid_drop();
    drive(0, 0, 0, 0);
    cycle();
    tests_run++;
    if ({s_q, cout_q, out_valid} !== 3'b110) begin
      tests_failed++;
      $display("FAIL valid_drop got %b exp %b", {s_q, cout_q, out_valid}, 3'b110);
    end
    tests_run++;
    if ({cout, s, cout_cnt} !== {2'b00, 8'd1}) begin
      tests_failed++;
      $display("FAIL valid_drop_comb_cnt got %b exp %b", {cout, s, cout_cnt}, {2'b00, 8'd1});
    end
  endtask

  task automatic test_counter();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 1'(k & 1), 1);
      cycle();
    end
    tests_run++;
    if (cout_cnt !== 8'd5) begin
      tests_failed++;
      $display("FAIL counter_five got %0d exp %0d", cout_cnt, 5);
    end
    drive(1, 0, 0, 1);
    cycle();
    drive(0, 0, 1, 1);
    cycle();
    tests_run++;
    if (cout_cnt !== 8'd5) begin
      tests_failed++;
      $display("FAIL counter_no_carry got %0d exp %0d", cout_cnt, 5);
    end
    tests_run++;
    if ({s_q, cout_q, out_valid} !== 3'b101) begin
      tests_failed++;
      $display("FAIL counter_last_result got %b exp %b", {s_q, cout_q, out_valid}, 3'b101);
    end
    // The two-bit counter saw five carry events and must sit at its ceiling.
    tests_run++;
    if (cout_cnt2 !== 2'd3) begin
      tests_failed++;
      $display("FAIL counter_sat_side got %0d exp %0d", cout_cnt2, 3);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [4];
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, 1);
      cycle();
      tests_run++;
      if (cout_cnt2 !== exp_sat[k]) begin
        tests_failed++;
        $display("FAIL saturation_op%0d got %0d exp %0d", k + 1, cout_cnt2, exp_sat[k]);
      end
    end
    tests_run++;
    if (cout_cnt !== 8'd4) begin
      tests_failed++;
      $display("FAIL saturation_wide got %0d exp %0d", cout_cnt, 4);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 1, 0, 1);
    cycle();
    tests_run++;
    if ({s_q, cout_q, out_valid} !== 3'b011) begin
      tests_failed++;
      $display("FAIL async_pre got %b exp %b", {s_q, cout_q, out_valid}, 3'b011);
    end
    // Assert reset mid-cycle with a valid operation still pending.
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({s_q, cout_q, out_valid, cout_cnt} !== 11'd0) begin
      tests_failed++;
      $display("FAIL async_clear got %b exp %b", {s_q, cout_q, out_valid, cout_cnt}, 11'd0);
    end
    tests_run++;
    if ({cout_cnt2, cout, s} !== 4'b0010) begin
      tests_failed++;
      $display("FAIL async_comb_sat got %b exp %b", {cout_cnt2, cout, s}, 4'b0010);
    end
    cycle();
    tests_run++;
    if ({s_q, cout_q, out_valid, cout_cnt} !== 11'd0) begin
      tests_failed++;
      $display("FAIL async_held got %b exp %b", {s_q, cout_q, out_valid, cout_cnt}, 11'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    a = 1'b1; b = 1'b0; cin = 1'b0; in_valid = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_before_edge got %b exp %b", out_valid, 1'b0);
    end
    cycle();
    tests_run++;
    if ({s_q, cout_q, out_valid, cout_cnt} !== {3'b101, 8'd0}) begin
      tests_failed++;
      $display("FAIL release_first_capture got %b exp %b", {s_q, cout_q, out_valid, cout_cnt}, {3'b101, 8'd0});
    end
  endtask

  initial begin
    rst = 1'b1;
    a = 1'b0; b = 1'b0; cin = 1'b0; in_valid = 1'b0;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_comb();
    test_registered();
    test_valid_drop();
    test_counter();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
